// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg -- shared definitions for the 8-way round-robin arbiter.
//   N_REQ       : number of requesters
//   ID_W        : width of a requester index
//   arb_state_e : arbiter FSM states
//   rr_pick()   : round-robin search helper, returns {found, index}
package rr_arb_pkg;
   localparam int N_REQ = 8;
   localparam int ID_W  = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // First set bit of req searching from last+1 upward with wrap.
   // The loop walks from the farthest candidate (last itself) toward the
   // nearest (last+1), so the nearest hit overwrites the result and wins.
   function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                             input logic [ID_W-1:0]  last);
      logic [ID_W:0]   res;
      logic [ID_W-1:0] idx;
      res = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         idx = last + ID_W'(i);
         if (req[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction
endpackage

// File: rtl/grant_decode3to8.sv
// grant_decode3to8 -- 3-to-8 one-hot decoder with enable.
//   idx    : binary index
//   en     : decode enable, output is all-zero when low
//   onehot : one-hot decode of idx
module grant_decode3to8
   import rr_arb_pkg::*;
(
   input  logic [ID_W-1:0]  idx,
   input  logic             en,
   output logic [N_REQ-1:0] onehot
);
   always_comb begin
      onehot = '0;
      if (en) onehot[idx] = 1'b1;
   end
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8 -- 8-requester round-robin arbiter with a bounded hold time.
//   clk       : clock, all state on rising edge
//   rst       : synchronous active-high reset
//   req       : per-requester request, held while the resource is wanted
//   gnt       : one-hot grant, zero when nobody owns the resource
//   gnt_id    : index of the current or most recent owner
//   gnt_valid : gnt is non-zero
//   timeout   : one-cycle pulse after a grant is revoked by hold expiry
module rr_arbiter8
   import rr_arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  gnt_id,
   output logic             gnt_valid,
   output logic             timeout
);
   localparam int HC_W = $clog2(MAX_HOLD);

   arb_state_e      state;
   logic [ID_W-1:0] last_id;
   logic [HC_W-1:0] hold_cnt;
   logic [ID_W:0]   pick;

   assign pick = rr_pick(req, last_id);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         gnt_id   <= 3'd7;
         last_id  <= 3'd7;
         hold_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (pick[ID_W]) begin
                  state    <= GRANT;
                  gnt_id   <= pick[ID_W-1:0];
                  hold_cnt <= '0;
               end
            end
            GRANT: begin
               // Release takes precedence over expiry: no timeout pulse then.
               if (!req[gnt_id]) begin
                  state   <= IDLE;
                  last_id <= gnt_id;
               end else if (hold_cnt == HC_W'(MAX_HOLD - 1)) begin
                  state   <= IDLE;
                  last_id <= gnt_id;
                  timeout <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Grant is decoded from flops only (state, gnt_id): no path from req.
   assign gnt_valid = (state == GRANT);

   grant_decode3to8 u_dec (
      .idx    (gnt_id),
      .en     (gnt_valid),
      .onehot (gnt)
   );
endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 16, meaning the maximum consecutive cycles one grant is held; legal range 2..256.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req, input, 8 bits: request per requester, held high while the resource is wanted.
REQ-005 The block SHALL have port gnt, output, 8 bits: one-hot grant, all-zero when no grant.
REQ-006 The block SHALL have port gnt_id, output, 3 bits: binary index of the current or last granted requester.
REQ-007 The block SHALL have port gnt_valid, output, 1 bit: high exactly when gnt is non-zero.
REQ-008 The block SHALL have port timeout, output, 1 bit: one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Function
REQ-009 The block SHALL use two FSM states: IDLE (no grant) and GRANT (one requester owns the resource).
REQ-010 In IDLE, if req is non-zero, the block SHALL select the first set bit searching from last_id+1 upward, wrapping 7->0, and enter GRANT at the next edge with gnt_id equal to that index.
REQ-011 In IDLE with req all-zero, the block SHALL remain in IDLE.
REQ-012 Latency from req sampled high in IDLE to gnt high SHALL be one clock.
REQ-013 In GRANT, gnt SHALL equal the 3-to-8 one-hot decode of gnt_id, and gnt_valid SHALL be 1.
REQ-014 In GRANT, when req[gnt_id] is sampled low, the block SHALL return to IDLE at that edge, so gnt is all-zero for at least one cycle before any new grant.
REQ-015 In GRANT, hold_cnt SHALL start at 0 on entry and increment each cycle; when hold_cnt equals MAX_HOLD-1 with req[gnt_id] still high, the block SHALL return to IDLE and pulse timeout for exactly that following cycle.
REQ-016 If release and expiry occur in the same cycle, the block SHALL treat the event as a release, with no timeout pulse.
REQ-017 On leaving GRANT, last_id SHALL be set to gnt_id, so the revoked or released requester has lowest priority in the next search.
REQ-018 A requester revoked by timeout that is the only requester SHALL be re-granted after one idle cycle.
REQ-019 Changes on req bits other than req[gnt_id] during GRANT SHALL NOT affect gnt.
REQ-020 gnt SHALL never have more than one bit set, and SHALL be driven from registers only, with no combinational path from req.
REQ-021 gnt_id SHALL hold its last value while in IDLE.
REQ-022 hold_cnt width SHALL be the minimum needed to represent MAX_HOLD-1.

Reset
REQ-023 On rst high at a clock edge, the block SHALL set state=IDLE, gnt=8'h00, gnt_valid=0, timeout=0, gnt_id=3'd7, last_id=3'd7 and hold_cnt=0.
REQ-024 rst asserted mid-grant SHALL drop gnt to zero at that edge, and the first grant after reset SHALL follow the search from index 0.
REQ-025 While rst is high, req SHALL be ignored.

Structure
REQ-026 A shared package rr_arb_pkg SHALL hold the FSM state enum (IDLE, GRANT), N_REQ=8 and ID_W=3.
REQ-027 The one-hot decode SHALL be a sub-module grant_decode3to8, taking a 3-bit index and an enable and producing an 8-bit one-hot output; no other sub-modules.

Verification
REQ-028 Reset then req=8'h01 held: gnt=8'h01 one cycle later, gnt_id=0, gnt_valid=1.
REQ-029 req=8'hFF held permanently with MAX_HOLD=4: grants rotate 0,1,2,...,7,0; each grant lasts 4 cycles, followed by a timeout pulse and one idle cycle.
REQ-030 req=8'h81 after reset, each requester dropping its req after 2 cycles of grant: order is 0 then 7 then 0, with a 1-cycle gap between grants.
REQ-031 rst pulsed during a grant to requester 5, with req=8'h24 held: gnt=0 at the reset edge, and the first grant after reset goes to requester 2.
REQ-032 req[3] alone held past MAX_HOLD=16: timeout pulse at cycle 17 of the grant, then gnt=8'h08 again after one idle cycle.
REQ-033 A checker SHALL assert, every cycle, that gnt is zero or one-hot, gnt_valid equals (gnt != 0), and gnt equals the one-hot decode of gnt_id whenever gnt_valid is 1.
